// File: rtl/bsg_cache_nb_dma_router.sv
// Routes non-blocking cache DMA packets: reads pass straight through to memory,
// writes are queued with their evict beats and replayed as packet then data burst.
module bsg_cache_nb_dma_router #(
  parameter int addr_width_p          = 32,
  parameter int word_width_p          = 32,
  parameter int block_size_in_words_p = 16,
  parameter int dma_data_width_p      = 256,
  parameter int mshr_els_p            = 4,
  localparam int mshr_id_width_lp     = (mshr_els_p > 1) ? $clog2(mshr_els_p) : 1,
  // Packet layout, MSB first: write_not_read, mask[block_size_in_words_p], mshr_id, addr
  localparam int pkt_width_lp         = 1 + block_size_in_words_p + mshr_id_width_lp + addr_width_p
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [pkt_width_lp-1:0]     cache_pkt_i,
  input  logic                        cache_pkt_v_i,
  output logic                        cache_pkt_yumi_o,
  input  logic [dma_data_width_p-1:0] cache_data_i,
  input  logic                        cache_data_v_i,
  output logic                        cache_data_yumi_o,
  output logic [pkt_width_lp-1:0]     rd_pkt_o,
  output logic                        rd_pkt_v_o,
  input  logic                        rd_pkt_yumi_i,
  output logic [pkt_width_lp-1:0]     wr_pkt_o,
  output logic                        wr_pkt_v_o,
  input  logic                        wr_pkt_yumi_i,
  output logic [dma_data_width_p-1:0] wr_data_o,
  output logic                        wr_data_v_o,
  input  logic                        wr_data_yumi_i
);

  localparam int bursts_raw_lp = block_size_in_words_p * word_width_p / dma_data_width_p;
  localparam int bursts_lp     = (bursts_raw_lp < 1) ? 1 : bursts_raw_lp;
  localparam int beat_w_lp     = (bursts_lp > 1) ? $clog2(bursts_lp) : 1;
  localparam int wrq_els_lp    = mshr_els_p;
  localparam int wrq_ptr_w_lp  = (wrq_els_lp > 1) ? $clog2(wrq_els_lp) : 1;
  localparam int wrq_cnt_w_lp  = $clog2(wrq_els_lp + 1);
  localparam int dq_els_lp     = mshr_els_p * bursts_lp;
  localparam int dq_ptr_w_lp   = (dq_els_lp > 1) ? $clog2(dq_els_lp) : 1;
  localparam int dq_cnt_w_lp   = $clog2(dq_els_lp + 1);

  localparam logic [beat_w_lp-1:0]    last_beat_lp = beat_w_lp'(bursts_lp - 1);
  localparam logic [wrq_cnt_w_lp-1:0] wrq_els_c    = wrq_cnt_w_lp'(wrq_els_lp);
  localparam logic [wrq_ptr_w_lp-1:0] wrq_last_c   = wrq_ptr_w_lp'(wrq_els_lp - 1);
  localparam logic [dq_cnt_w_lp-1:0]  dq_els_c     = dq_cnt_w_lp'(dq_els_lp);
  localparam logic [dq_ptr_w_lp-1:0]  dq_last_c    = dq_ptr_w_lp'(dq_els_lp - 1);

  typedef enum logic [0:0] {IDLE, DATA} wrState_t;

  wrState_t                    r_state, w_nextState;
  logic                        r_ready;
  logic                        w_live;
  logic                        w_isWrite;
  logic [pkt_width_lp-1:0]     r_wrqMem [wrq_els_lp];
  logic [wrq_ptr_w_lp-1:0]     r_wrqHead, r_wrqTail;
  logic [wrq_cnt_w_lp-1:0]     r_wrqCount;
  logic                        w_wrqFull, w_wrqEmpty, w_wrqPush, w_wrqPop;
  logic [dma_data_width_p-1:0] r_dqMem [dq_els_lp];
  logic [dq_ptr_w_lp-1:0]      r_dqHead, r_dqTail;
  logic [dq_cnt_w_lp-1:0]      r_dqCount;
  logic                        w_dqFull, w_dqEmpty, w_dqPush, w_dqPop;
  logic [beat_w_lp-1:0]        r_beat;
  logic                        w_lastBeat;

  // Handshakes stay quiet through reset and the cycle right after it.
  always_ff @(posedge clk) begin
    if (reset) r_ready <= 1'b0;
    else       r_ready <= 1'b1;
  end

  assign w_live    = r_ready & ~reset;
  assign w_isWrite = cache_pkt_i[pkt_width_lp-1];

  assign w_wrqFull  = (r_wrqCount == wrq_els_c);
  assign w_wrqEmpty = (r_wrqCount == '0);
  assign w_dqFull   = (r_dqCount == dq_els_c);
  assign w_dqEmpty  = (r_dqCount == '0);

  // Reads wait for an empty write queue so they never overtake a pending write.
  assign rd_pkt_o          = cache_pkt_i;
  assign rd_pkt_v_o        = w_live & cache_pkt_v_i & ~w_isWrite & w_wrqEmpty;
  assign w_wrqPush         = w_live & cache_pkt_v_i & w_isWrite & ~w_wrqFull;
  assign cache_pkt_yumi_o  = w_wrqPush | (rd_pkt_yumi_i & rd_pkt_v_o);
  assign w_dqPush          = w_live & cache_data_v_i & ~w_dqFull;
  assign cache_data_yumi_o = w_dqPush;

  assign w_dqPop    = wr_data_v_o & wr_data_yumi_i;
  assign w_lastBeat = (r_beat == last_beat_lp);
  assign w_wrqPop   = w_dqPop & w_lastBeat;

  assign wr_pkt_o  = r_wrqMem[r_wrqHead];
  assign wr_data_o = r_dqMem[r_dqHead];

  always_ff @(posedge clk) begin
    if (w_wrqPush) r_wrqMem[r_wrqTail] <= cache_pkt_i;
    if (w_dqPush)  r_dqMem[r_dqTail]   <= cache_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrqHead  <= '0;
      r_wrqTail  <= '0;
      r_wrqCount <= '0;
    end else begin
      if (w_wrqPush) r_wrqTail <= (r_wrqTail == wrq_last_c) ? '0 : r_wrqTail + 1'b1;
      if (w_wrqPop)  r_wrqHead <= (r_wrqHead == wrq_last_c) ? '0 : r_wrqHead + 1'b1;
      r_wrqCount <= r_wrqCount + wrq_cnt_w_lp'(w_wrqPush) - wrq_cnt_w_lp'(w_wrqPop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dqHead  <= '0;
      r_dqTail  <= '0;
      r_dqCount <= '0;
    end else begin
      if (w_dqPush) r_dqTail <= (r_dqTail == dq_last_c) ? '0 : r_dqTail + 1'b1;
      if (w_dqPop)  r_dqHead <= (r_dqHead == dq_last_c) ? '0 : r_dqHead + 1'b1;
      r_dqCount <= r_dqCount + dq_cnt_w_lp'(w_dqPush) - dq_cnt_w_lp'(w_dqPop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        r_beat <= '0;
    else if (w_dqPop) r_beat <= w_lastBeat ? '0 : r_beat + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (wr_pkt_v_o & wr_pkt_yumi_i) w_nextState = DATA;
      DATA:    if (w_wrqPop) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    wr_pkt_v_o  = 1'b0;
    wr_data_v_o = 1'b0;
    case (r_state)
      IDLE:    wr_pkt_v_o  = w_live & ~w_wrqEmpty;
      DATA:    wr_data_v_o = w_live & ~w_dqEmpty;
      default: ;
    endcase
  end

  assert property (@(posedge clk) disable iff (reset) wr_data_yumi_i |-> wr_data_v_o)
    else $error("wr_data_yumi_i asserted without wr_data_v_o");
  assert property (@(posedge clk) disable iff (reset) wr_pkt_yumi_i |-> wr_pkt_v_o)
    else $error("wr_pkt_yumi_i asserted without wr_pkt_v_o");
  assert property (@(posedge clk) disable iff (reset) rd_pkt_yumi_i |-> rd_pkt_v_o)
    else $error("rd_pkt_yumi_i asserted without rd_pkt_v_o");

endmodule

// File: tb/tb_bsg_cache_nb_dma_router.sv
// Directed bench for bsg_cache_nb_dma_router: read bypass, write replay, ordering,
// back-pressure, mid-operation reset and a long run with random memory stalls.
module tb_bsg_cache_nb_dma_router;

  localparam int PKT_W  = 1 + 16 + 2 + 32;
  localparam int DATA_W = 256;

  logic              clk;
  logic              reset;
  logic [PKT_W-1:0]  cache_pkt_i;
  logic              cache_pkt_v_i;
  logic              cache_pkt_yumi_o;
  logic [DATA_W-1:0] cache_data_i;
  logic              cache_data_v_i;
  logic              cache_data_yumi_o;
  logic [PKT_W-1:0]  rd_pkt_o;
  logic              rd_pkt_v_o;
  logic              rd_pkt_yumi_i;
  logic [PKT_W-1:0]  wr_pkt_o;
  logic              wr_pkt_v_o;
  logic              wr_pkt_yumi_i;
  logic [DATA_W-1:0] wr_data_o;
  logic              wr_data_v_o;
  logic              wr_data_yumi_i;

  logic rdReady, wrPktReady, wrDataReady, randStall, rstNext;
  int   errors, checks;
  logic [DATA_W-1:0] gotBeats [$];
  logic [31:0]       gotPkts  [$];

  bsg_cache_nb_dma_router dut (
    .clk              (clk),
    .reset            (reset),
    .cache_pkt_i      (cache_pkt_i),
    .cache_pkt_v_i    (cache_pkt_v_i),
    .cache_pkt_yumi_o (cache_pkt_yumi_o),
    .cache_data_i     (cache_data_i),
    .cache_data_v_i   (cache_data_v_i),
    .cache_data_yumi_o(cache_data_yumi_o),
    .rd_pkt_o         (rd_pkt_o),
    .rd_pkt_v_o       (rd_pkt_v_o),
    .rd_pkt_yumi_i    (rd_pkt_yumi_i),
    .wr_pkt_o         (wr_pkt_o),
    .wr_pkt_v_o       (wr_pkt_v_o),
    .wr_pkt_yumi_i    (wr_pkt_yumi_i),
    .wr_data_o        (wr_data_o),
    .wr_data_v_o      (wr_data_v_o),
    .wr_data_yumi_i   (wr_data_yumi_i)
  );

  // Memory side only accepts what is actually offered.
  assign rd_pkt_yumi_i  = rdReady & rd_pkt_v_o;
  assign wr_pkt_yumi_i  = wrPktReady & wr_pkt_v_o;
  assign wr_data_yumi_i = wrDataReady & wr_data_v_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PKT_W-1:0] mkPkt(input logic wnr, input logic [31:0] addr);
    return {wnr, 16'hFFFF, 2'd0, addr};
  endfunction

  function automatic logic [DATA_W-1:0] mkBeat(input logic [31:0] tag);
    return {8{tag}};
  endfunction

  // Logs the previous cycle's memory handshakes, then drives one new cycle.
  task automatic applyStimulus(input logic pktV, input logic [PKT_W-1:0] pkt,
                               input logic dataV, input logic [DATA_W-1:0] data);
    if (wr_data_v_o && wr_data_yumi_i) gotBeats.push_back(wr_data_o);
    if (wr_pkt_v_o && wr_pkt_yumi_i) gotPkts.push_back(wr_pkt_o[31:0]);
    @(negedge clk);
    reset          = rstNext;
    cache_pkt_v_i  = pktV;
    cache_pkt_i    = pkt;
    cache_data_v_i = dataV;
    cache_data_i   = data;
    if (randStall) begin
      wrPktReady  = 1'($urandom_range(0, 1));
      wrDataReady = 1'($urandom_range(0, 1));
    end
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput(tag, {rd_pkt_v_o, cache_pkt_yumi_o, cache_data_yumi_o, wr_pkt_v_o, wr_data_v_o}, '0);
  endtask

  initial begin
    logic [PKT_W-1:0] rdA, wA, wC, rdC, wE, wF, w5;
    int pktsSent, beatsSent;
    errors = 0; checks = 0;
    rdReady = 1'b1; wrPktReady = 1'b1; wrDataReady = 1'b1; randStall = 1'b0; rstNext = 1'b1;
    reset = 1'b1; cache_pkt_v_i = 1'b0; cache_pkt_i = '0; cache_data_v_i = 1'b0; cache_data_i = '0;
    rdA = mkPkt(1'b0, 32'h0000_0800);
    wA  = mkPkt(1'b1, 32'h0000_1000);
    wC  = mkPkt(1'b1, 32'h0000_1040);
    rdC = mkPkt(1'b0, 32'h0000_1040);
    w5  = mkPkt(1'b1, 32'h0000_3000);
    wE  = mkPkt(1'b1, 32'h0000_5000);
    wF  = mkPkt(1'b1, 32'h0000_6000);

    // Reset and the first cycle after it: nothing handshakes even with a read offered.
    repeat (3) applyStimulus(1'b1, rdA, 1'b1, mkBeat(32'h1));
    checkQuiet("quietInReset");
    rstNext = 1'b0;
    applyStimulus(1'b1, rdA, 1'b0, '0);
    checkQuiet("quietAfterReset");

    // Read passes straight through with zero latency.
    applyStimulus(1'b1, rdA, 1'b0, '0);
    checkOutput("rdValid", rd_pkt_v_o, 1'b1);
    checkOutput("rdYumi", cache_pkt_yumi_o, 1'b1);
    checkOutput("rdPkt", rd_pkt_o, rdA);

    // Single write with two beats, memory always ready.
    applyStimulus(1'b1, wA, 1'b1, mkBeat(32'hA));
    checkOutput("wrEnqYumi", {cache_pkt_yumi_o, cache_data_yumi_o, wr_pkt_v_o}, 3'b110);
    applyStimulus(1'b0, '0, 1'b1, mkBeat(32'hB));
    checkOutput("wrPktValid", wr_pkt_v_o, 1'b1);
    checkOutput("wrPkt", wr_pkt_o, wA);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("wrBeatAValid", {wr_data_v_o, wr_pkt_v_o}, 2'b10);
    checkOutput("wrBeatA", wr_data_o, mkBeat(32'hA));
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("wrBeatB", wr_data_o, mkBeat(32'hB));
    applyStimulus(1'b1, rdA, 1'b0, '0);
    checkOutput("wrBackIdle", {wr_data_v_o, wr_pkt_v_o, rd_pkt_v_o}, 3'b001);

    // Read behind a write waits until the last beat is accepted.
    applyStimulus(1'b1, wC, 1'b1, mkBeat(32'hA2));
    applyStimulus(1'b1, rdC, 1'b1, mkBeat(32'hB2));
    checkOutput("rdBlockedPkt", {rd_pkt_v_o, wr_pkt_v_o}, 2'b01);
    applyStimulus(1'b1, rdC, 1'b0, '0);
    checkOutput("rdBlockedBeatA", {rd_pkt_v_o, wr_data_o}, {1'b0, mkBeat(32'hA2)});
    applyStimulus(1'b1, rdC, 1'b0, '0);
    checkOutput("rdBlockedBeatB", {rd_pkt_v_o, wr_data_o}, {1'b0, mkBeat(32'hB2)});
    applyStimulus(1'b1, rdC, 1'b0, '0);
    checkOutput("rdReleased", {rd_pkt_v_o, cache_pkt_yumi_o}, 2'b11);

    // Fill the write queue and data queue while memory refuses packets.
    wrPktReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, mkPkt(1'b1, 32'h2000 + 32'(i) * 64), 1'b1, mkBeat(32'h20 + 32'(2 * i)));
      checkOutput($sformatf("fillPkt%0d", i), {cache_pkt_yumi_o, cache_data_yumi_o}, 2'b11);
      applyStimulus(1'b0, '0, 1'b1, mkBeat(32'h21 + 32'(2 * i)));
      checkOutput($sformatf("fillBeat%0d", i), cache_data_yumi_o, 1'b1);
    end
    applyStimulus(1'b1, w5, 1'b1, mkBeat(32'h30));
    checkOutput("fullBlocks", {cache_pkt_yumi_o, cache_data_yumi_o, wr_pkt_v_o}, 3'b001);
    wrPktReady = 1'b1;
    applyStimulus(1'b1, w5, 1'b1, mkBeat(32'h30));
    checkOutput("fullBeat0", {cache_pkt_yumi_o, cache_data_yumi_o, wr_data_o}, {2'b00, mkBeat(32'h20)});
    applyStimulus(1'b1, w5, 1'b1, mkBeat(32'h30));
    checkOutput("fullBeat1", {cache_pkt_yumi_o, cache_data_yumi_o, wr_data_o}, {2'b01, mkBeat(32'h21)});
    applyStimulus(1'b1, w5, 1'b1, mkBeat(32'h31));
    checkOutput("fullReleased", {cache_pkt_yumi_o, cache_data_yumi_o}, 2'b11);
    repeat (20) applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("drainLastBeat", gotBeats[$], mkBeat(32'h31));
    checkOutput("drainLastPkt", gotPkts[$], 32'h3000);
    applyStimulus(1'b1, rdA, 1'b0, '0);
    checkOutput("drainEmpty", rd_pkt_v_o, 1'b1);

    // Reset in the middle of a data burst discards the stale beat.
    applyStimulus(1'b1, wE, 1'b1, mkBeat(32'h50));
    applyStimulus(1'b0, '0, 1'b1, mkBeat(32'h51));
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("preResetBeat", wr_data_o, mkBeat(32'h50));
    rstNext = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkQuiet("midResetQuiet");
    rstNext = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkQuiet("midResetAfterQuiet");
    applyStimulus(1'b1, wF, 1'b1, mkBeat(32'hC));
    checkOutput("postResetEnq", cache_pkt_yumi_o, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, mkBeat(32'hD));
    checkOutput("postResetPkt", {wr_pkt_v_o, wr_pkt_o}, {1'b1, wF});
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("postResetBeatC", {wr_data_v_o, wr_data_o}, {1'b1, mkBeat(32'hC)});
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("postResetBeatD", {wr_data_v_o, wr_data_o}, {1'b1, mkBeat(32'hD)});
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("postResetIdle", {wr_data_v_o, wr_pkt_v_o}, 2'b00);

    // 100 writes against random memory stalls; order and count must be exact.
    gotBeats.delete();
    gotPkts.delete();
    pktsSent = 0; beatsSent = 0; randStall = 1'b1;
    for (int cyc = 0; cyc < 4000 && gotBeats.size() < 200; cyc++) begin
      applyStimulus(pktsSent < 100, mkPkt(1'b1, 32'h4000_0000 + 32'(pktsSent) * 64),
                    beatsSent < 200, mkBeat(32'hD000_0000 + 32'(beatsSent)));
      if (cache_pkt_yumi_o) pktsSent++;
      if (cache_data_yumi_o) beatsSent++;
    end
    randStall = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("stallBeatCount", 256'(gotBeats.size()), 256'd200);
    checkOutput("stallPktCount", 256'(gotPkts.size()), 256'd100);
    for (int k = 0; k < gotBeats.size(); k++)
      checkOutput($sformatf("stallBeat%0d", k), gotBeats[k], mkBeat(32'hD000_0000 + 32'(k)));
    for (int k = 0; k < gotPkts.size(); k++)
      checkOutput($sformatf("stallPkt%0d", k), gotPkts[k], 32'h4000_0000 + 32'(k) * 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
